// File: rtl/servo_ramp_ctrl_if.sv
// Command port of servo_ramp_ctrl: a valid/ready handshake carrying a
// channel index and a requested pulse width, plus an error pulse back.
interface servo_ramp_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_ch;
  logic [15:0] cmd_us;
  logic        cmd_err;

  // Command source (e.g. a host or testbench)
  modport master (
    output cmd_valid, cmd_ch, cmd_us,
    input  cmd_ready, cmd_err
  );

  // Command sink (the ramp controller)
  modport slave (
    input  cmd_valid, cmd_ch, cmd_us,
    output cmd_ready, cmd_err
  );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// Servo ramp controller: holds a clamped target width per channel and, once
// per frame, walks every channel's current width toward its target by at most
// STEP_US. Current widths drive downstream per-channel PWM generators.
module servo_ramp_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int FRAME_US = 20_000,
  parameter int NUM_CH   = 4,
  parameter int STEP_US  = 20,
  parameter int MIN_US   = 1_000,
  parameter int MAX_US   = 2_000,
  parameter int HOME_US  = 1_500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  servo_ramp_ctrl_if.slave       cmd_if,
  output logic [16*NUM_CH-1:0]   width_us_o,
  output logic                   frame_tick_o,
  output logic                   settled_o
);

  localparam int FRAME_TICKS = FRAME_US * (CLK_HZ / 1_000_000);
  localparam int CNT_W       = $clog2(FRAME_TICKS);
  localparam int IDX_W       = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             frame_tick_q;
  logic             cmd_err_q;

  logic             cmd_accept;
  logic             cmd_ch_bad;
  logic [15:0]      clamp_us;
  logic             update_en;
  logic [NUM_CH-1:0] ch_eq;

  // Ready only in IDLE and never while reset is held
  assign cmd_if.cmd_ready = rst_n && (state_q == IDLE);
  assign cmd_accept       = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign cmd_ch_bad       = ({1'b0, cmd_if.cmd_ch} >= 4'(NUM_CH));
  assign cmd_if.cmd_err   = cmd_err_q;
  assign frame_tick_o     = frame_tick_q;
  assign update_en        = (state_q == UPDATE);
  assign settled_o        = &ch_eq;

  // Requested width clamped into the legal servo range
  always_comb begin
    clamp_us = cmd_if.cmd_us;
    if (cmd_if.cmd_us < 16'(MIN_US))      clamp_us = 16'(MIN_US);
    else if (cmd_if.cmd_us > 16'(MAX_US)) clamp_us = 16'(MAX_US);
  end

  // Frame counter, tick pulse, error pulse and the IDLE/UPDATE sweep FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      frame_tick_q <= (cnt_q == CNT_LAST);
      cnt_q        <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      cmd_err_q    <= cmd_accept && cmd_ch_bad;
      case (state_q)
        IDLE: begin
          if (frame_tick_q && enable_i) begin
            state_q <= UPDATE;
            idx_q   <= '0;
          end
        end
        UPDATE: begin
          // enable is deliberately ignored here: a started sweep always completes
          if (idx_q == IDX_LAST) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [15:0] cur_q;
      logic [15:0] tgt_q;
      logic [15:0] cur_d;
      logic [16:0] up_sum;
      logic [16:0] dn_lim;

      // One step toward target, saturating at the target (17-bit math, no wrap)
      always_comb begin
        up_sum = {1'b0, cur_q} + 17'(STEP_US);
        dn_lim = {1'b0, tgt_q} + 17'(STEP_US);
        cur_d  = cur_q;
        if (cur_q < tgt_q) begin
          cur_d = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[15:0];
        end else if (cur_q > tgt_q) begin
          cur_d = ({1'b0, cur_q} <= dn_lim) ? tgt_q : cur_q - 16'(STEP_US);
        end
      end

      // Target written by accepted commands; current width stepped in its sweep slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cur_q <= 16'(HOME_US);
          tgt_q <= 16'(HOME_US);
        end else begin
          if (update_en && (idx_q == IDX_W'(gi))) cur_q <= cur_d;
          if (cmd_accept && !cmd_ch_bad && (cmd_if.cmd_ch == 3'(gi))) tgt_q <= clamp_us;
        end
      end

      assign ch_eq[gi]                = (cur_q == tgt_q);
      assign width_us_o[16*gi +: 16]  = cur_q;
    end
  endgenerate

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with a 100-cycle frame and 4 channels.
module tb_servo_ramp_ctrl;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [63:0] width_us;
  logic        frame_tick;
  logic        settled;
  int          n_cmp = 0;
  int          n_err = 0;

  servo_ramp_ctrl_if cif();

  servo_ramp_ctrl #(
    .CLK_HZ(1_000_000), .FRAME_US(100), .NUM_CH(4), .STEP_US(20),
    .MIN_US(1_000), .MAX_US(2_000), .HOME_US(1_500)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_i(enable),
    .cmd_if(cif),
    .width_us_o(width_us),
    .frame_tick_o(frame_tick),
    .settled_o(settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] w(input int k);
    return width_us[16*k +: 16];
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Returns at the falling edge of the frame_tick cycle; n = rising edges waited
  task automatic wait_tick(output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (frame_tick) break;
    end
    if (!frame_tick) check_val("tick_timeout", 0, 1);
  endtask

  // Wait for a tick, then let the whole 4-channel sweep finish
  task automatic run_frame();
    int n;
    wait_tick(n);
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one command; returns at the falling edge after the accepting edge
  task automatic send_cmd(input logic [2:0] ch, input logic [15:0] us);
    int guard = 0;
    while (!cif.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 50) check_val("ready_timeout", 0, 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_ch    = ch;
    cif.cmd_us    = us;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    int ticks;
    int t1;
    int t2;
    rst_n = 1'b0;
    enable = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_ch = 3'd0;
    cif.cmd_us = 16'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_ready", cif.cmd_ready, 0);
    check_val("rst_tick", frame_tick, 0);
    check_val("rst_err", cif.cmd_err, 0);
    check_val("rst_w0", w(0), 1500);
    rst_n = 1'b1;
    #1;
    check_val("rel_ready", cif.cmd_ready, 1);
    check_val("rel_settled", settled, 1);

    // Idle 250 cycles: ticks at 100 and 200
    ticks = 0; t1 = 0; t2 = 0;
    for (int i = 1; i <= 250; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_tick) begin
        ticks++;
        if (ticks == 1) t1 = i;
        if (ticks == 2) t2 = i;
      end
    end
    check_val("tick_count", ticks, 2);
    check_val("tick_first", t1, 100);
    check_val("tick_second", t2, 200);
    for (int k = 0; k < 4; k++) check_val($sformatf("idle_w%0d", k), w(k), 1500);
    check_val("idle_settled", settled, 1);

    // ch1 -> 1550 over three frames
    enable = 1'b1;
    send_cmd(3'd1, 16'd1550);
    check_val("c1_err", cif.cmd_err, 0);
    check_val("c1_settled0", settled, 0);
    run_frame(); check_val("c1_f1", w(1), 1520); check_val("c1_set1", settled, 0);
    run_frame(); check_val("c1_f2", w(1), 1540); check_val("c1_set2", settled, 0);
    run_frame(); check_val("c1_f3", w(1), 1550); check_val("c1_set3", settled, 1);
    run_frame(); check_val("c1_hold", w(1), 1550);

    // ch2 -> 500 clamps to 1000, 25 frames to get there
    send_cmd(3'd2, 16'd500);
    for (int f = 1; f <= 26; f++) begin
      run_frame();
      if (f == 1) begin
        check_val("c2_f1", w(2), 1480);
        check_val("c2_ch1_keep", w(1), 1550);
      end
      if (f == 24) check_val("c2_f24", w(2), 1020);
      if (f == 25) check_val("c2_f25", w(2), 1000);
      if (f == 26) begin
        check_val("c2_f26", w(2), 1000);
        check_val("c2_settled", settled, 1);
      end
    end

    // ch3 -> 3000 clamps to 2000
    send_cmd(3'd3, 16'd3000);
    run_frame(); check_val("c3_f1", w(3), 1520);

    // enable low freezes widths across frames
    enable = 1'b0;
    run_frame(); check_val("dis_f1", w(3), 1520);
    run_frame(); check_val("dis_f2", w(3), 1520);
    enable = 1'b1;
    run_frame(); check_val("en_resume", w(3), 1540);

    // Out-of-range channel: error pulse, no target touched
    send_cmd(3'd6, 16'd1800);
    check_val("bad_err_hi", cif.cmd_err, 1);
    @(posedge clk); @(negedge clk);
    check_val("bad_err_lo", cif.cmd_err, 0);
    run_frame();
    check_val("bad_w0", w(0), 1500);
    check_val("bad_w1", w(1), 1550);
    check_val("bad_w2", w(2), 1000);
    check_val("bad_w3", w(3), 1560);

    // cmd_valid held through UPDATE is not accepted until IDLE
    wait_tick(n);
    @(posedge clk); @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_ch = 3'd0;
    cif.cmd_us = 16'd1700;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("upd_ready%0d", i), cif.cmd_ready, 0);
      @(posedge clk); @(negedge clk);
    end
    check_val("upd_ready_back", cif.cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cif.cmd_valid = 1'b0;
    check_val("hold_w0", w(0), 1500);
    check_val("hold_w3", w(3), 1580);
    run_frame();
    check_val("hold_w0_next", w(0), 1520);
    check_val("hold_w3_next", w(3), 1600);

    // Command in the frame_tick cycle is used in that same sweep
    wait_tick(n);
    cif.cmd_valid = 1'b1;
    cif.cmd_ch = 3'd0;
    cif.cmd_us = 16'd1400;
    @(posedge clk); @(negedge clk);
    cif.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("same_tick_w0", w(0), 1500);
    check_val("same_tick_w3", w(3), 1620);

    // Reset in UPDATE cycle 2 discards everything
    wait_tick(n);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) check_val($sformatf("midrst_w%0d", k), w(k), 1500);
    check_val("midrst_ready", cif.cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("midrst_settled", settled, 1);
    check_val("midrst_ready_rel", cif.cmd_ready, 1);
    wait_tick(n);
    check_val("midrst_tick_dist", n, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
